// File: rtl/dot_product_accumulator_if.sv
// Term-in / element-out handshake bundle for the dot-product accumulator.
interface dot_product_accumulator_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums K_LEN unsigned terms per matrix element with a sticky carry-out flag,
// then holds the finished element until the result writer accepts it.
module dot_product_accumulator #(
  parameter int WIDTH = 32,
  parameter int K_LEN = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  dot_product_accumulator_if.slave  bus,
  output logic                      busy
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc_p1;
  logic             ovf_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic [WIDTH-1:0] sum_p2;
  logic             ovf_p2;
  logic             busy_q;

  logic             take;
  logic             last_term;
  logic [WIDTH:0]   sum_c;
  logic             ovf_next;

  function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign take      = bus.in_valid && (state == ACCUM);
  assign last_term = (cnt_p1 == CNT_W'(K_LEN - 1));
  assign sum_c     = add_carry(acc_p1, bus.in_data);
  assign ovf_next  = ovf_p1 | sum_c[WIDTH];

  // Accumulate stage -> result hold stage; acc is cleared as the element
  // leaves ACCUM, so the next element starts from zero without extra logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ACCUM;
      acc_p1 <= '0;
      ovf_p1 <= 1'b0;
      cnt_p1 <= '0;
      sum_p2 <= '0;
      ovf_p2 <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (take) begin
            busy_q <= 1'b1;
            if (last_term) begin
              state  <= HOLD;
              sum_p2 <= sum_c[WIDTH-1:0];
              ovf_p2 <= ovf_next;
              cnt_p1 <= '0;
              acc_p1 <= '0;
              ovf_p1 <= 1'b0;
            end else begin
              acc_p1 <= sum_c[WIDTH-1:0];
              ovf_p1 <= ovf_next;
              cnt_p1 <= cnt_p1 + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state  <= ACCUM;
            busy_q <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // Handshake outputs are pure decodes of registered state.
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = sum_p2;
  assign bus.out_ovf   = ovf_p2;
  assign busy          = busy_q;

endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Sequential accumulation stage directly downstream of the 32-bit unsigned adder datapath in the matrix multiplier.
- Accepts a stream of K unsigned 32-bit partial products for one output matrix element, one per handshake. Sums them into a 32-bit accumulator and keeps a sticky carry-out (overflow) flag.
- Presents the finished element with a valid/ready handshake to the result writer.
- Produces one matrix element per K accepted terms. Runs back-to-back across elements.

Parameters:
- WIDTH, 32, operand and accumulator width in bits; unsigned.
- K_LEN, 4, number of terms per dot product; legal range 1..65535.
- CNT_W, 16, width of the term counter; must satisfy 2^CNT_W > K_LEN.

Ports:
- clk  in  1  rising-edge clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream term available.
- in_ready  out  1  block can accept a term this cycle.
- in_data  in  WIDTH  unsigned term (partial product).
- out_valid  out  1  finished element held on out_sum/out_ovf.
- out_ready  in  1  downstream accepts element this cycle.
- out_sum  out  WIDTH  accumulated sum modulo 2^WIDTH.
- out_ovf  out  1  set if any addition in this element carried out of bit WIDTH-1.
- busy  out  1  at least one term of the current element accepted and not yet delivered.

Behaviour:
- Reset: one clk with rst=1 forces state=ACCUM and clears the accumulator, counter and sticky flag. After reset: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- A reset asserted mid-element or mid-HOLD discards all partial state. No output is produced for that element.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Input transfer occurs on a clk edge where in_valid & in_ready. On transfer:
  - acc <= acc + in_data (WIDTH-bit, unsigned).
  - ovf <= ovf | carry_out.
  - cnt <= cnt + 1.
- The first term of an element adds to an acc of 0. It is a plain load plus carry, and carry is always 0 for that term.
- When the transfer carries the K_LEN-th term (cnt == K_LEN-1 before the edge):
  - state -> HOLD.
  - out_sum/out_ovf <= final acc/ovf, including this term's carry.
  - cnt resets to 0.
- Latency: out_valid rises on the edge of the K_LEN-th transfer, i.e. visible the cycle after that term is offered.
- HOLD:
  - out_sum and out_ovf are stable while out_valid=1 and out_ready=0.
  - On out_ready=1: state -> ACCUM, acc and ovf cleared, out_valid drops the next cycle.
  - in_ready becomes 1 the same cycle out_valid drops.
  - Min period per element: K_LEN+1 cycles.
- in_data is ignored and accumulator unchanged on cycles without a transfer, including in_valid=1 while in HOLD.
- K_LEN=1: every accepted term goes straight to HOLD. out_sum=in_data, out_ovf=0.
- Wrap-around: the sum is modulo 2^WIDTH; ovf is sticky until the element is delivered, even if later additions do not carry.
- busy=1 from the first accepted term of an element until the out_ready handshake completes; 0 otherwise.
- out_sum/out_ovf retain the last delivered values while out_valid=0. They are defined, but downstream must not sample them.
- No combinational path from in_valid to in_ready, or from out_ready to in_ready; both are pure state decodes.

Test Plan:
- Reset then terms 1,2,3,4 on consecutive cycles, out_ready=1 -> out_valid high one cycle after term 4, out_sum=10, out_ovf=0; in_ready high again the following cycle.
- Terms 0xFFFFFFFF,0x00000002,0,0 -> out_sum=0x00000001, out_ovf=1. Next element 5,5,5,5 -> out_sum=20, out_ovf=0 (sticky flag cleared between elements).
- Element 7,7,7,7 with out_ready held 0 for 5 cycles while in_valid=1 with data 9 -> out_sum stays 28 and in_ready=0 throughout. After out_ready pulse the next element sums to 36 from the four 9s.
- in_valid gaps: terms 10,(idle 3 cycles),20,(idle),30,40 -> out_sum=100; busy=1 from first term through delivery.
- Reset asserted after 2 of 4 terms (100,200), then terms 1,1,1,1 -> out_sum=4, no result produced for the aborted element.
- K_LEN=1 build: terms 0xDEADBEEF,0x12345678 with out_ready=1 -> two results in 4 cycles matching the inputs, out_ovf=0.
